// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between control/branch logic and the PC sequencer.
// The control logic drives the selects and targets; the sequencer drives the fetch address and status.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             restart;
  logic [1:0]       pc_sel;
  logic             br_taken;
  logic [WIDTH-1:0] br_offset;
  logic [25:0]      jump_target;
  logic [WIDTH-1:0] jr_addr;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             pc_valid;
  logic             halted;
  logic             fault;
  logic [WIDTH-1:0] fault_pc;

  modport master (
    output stall, restart, pc_sel, br_taken, br_offset, jump_target, jr_addr,
    input  pc, pc_plus4, pc_valid, halted, fault, fault_pc
  );

  modport slave (
    input  stall, restart, pc_sel, br_taken, br_offset, jump_target, jr_addr,
    output pc, pc_plus4, pc_valid, halted, fault, fault_pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS fetch-stage program counter: next-PC select, stall, and range/alignment
// checking of every target, with a sticky fault record held in HALT.
//
//   state | meaning
//   BOOT  | one settling cycle after reset/restart, pc = RESET_VECTOR, not yet valid
//   RUN   | live fetch, pc advances from the selected source unless stalled
//   HALT  | illegal target seen, everything frozen until restart or reset
module pc_sequencer #(
  parameter int WIDTH        = 32,
  parameter int RESET_VECTOR = 0,
  parameter int IMEM_BYTES   = 32768
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] IMEM_END = WIDTH'(IMEM_BYTES);
  localparam logic [WIDTH-1:0] LOW28    = WIDTH'(28'hFFF_FFFF);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] fault_pc_q, fault_pc_d;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] target;
  logic             illegal;

  assign seq_pc = pc_q + WIDTH'(4);

  // Jump keeps the region bits above bit 27 of pc+4; masking avoids a part-select that vanishes at WIDTH=28.
  always_comb begin
    target = seq_pc;
    case (bus.pc_sel)
      2'b00: target = seq_pc;
      2'b01: target = bus.br_taken ? (seq_pc + (bus.br_offset << 2)) : seq_pc;
      2'b10: target = (seq_pc & ~LOW28) | WIDTH'({bus.jump_target, 2'b00});
      2'b11: target = bus.jr_addr;
      default: target = seq_pc;
    endcase
  end

  assign illegal = (target >= IMEM_END) || (target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (bus.restart) begin
      state_d    = BOOT;
      pc_d       = RST_PC;
      valid_d    = 1'b0;
      halted_d   = 1'b0;
      fault_d    = 1'b0;
      fault_pc_d = '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = RUN;
          valid_d = 1'b1;
        end
        RUN: begin
          if (!bus.stall) begin
            if (illegal) begin
              state_d    = HALT;
              valid_d    = 1'b0;
              halted_d   = 1'b1;
              fault_d    = 1'b1;
              fault_pc_d = target;
            end else begin
              pc_d = target;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state_d = BOOT;
          pc_d    = RST_PC;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RST_PC;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = seq_pc;
  assign bus.pc_valid = valid_q;
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;
  assign bus.fault_pc = fault_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test-plan steps followed by randomized traffic, all checked
// against a behavioural next-PC model kept in the bench.
module tb_pc_sequencer;
  localparam int W  = 32;
  localparam int RV = 0;
  localparam int IB = 32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pc_sequencer_if #(.WIDTH(W)) bus ();

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV), .IMEM_BYTES(IB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_valid, m_halted, m_fault, m_booting;
  logic [31:0] m_fpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("pc_valid", {31'd0, bus.pc_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, bus.halted}, {31'd0, m_halted});
    chk("fault", {31'd0, bus.fault}, {31'd0, m_fault});
    chk("fault_pc", bus.fault_pc, m_fpc);
  endtask

  task automatic model_reset();
    m_pc = RV; m_valid = 0; m_halted = 0; m_fault = 0; m_fpc = 0; m_booting = 1;
  endtask

  // Model the effect of one rising edge using the currently applied inputs.
  task automatic model_edge();
    logic [31:0] nxt, t;
    nxt = m_pc + 32'd4;
    if (bus.restart) begin
      model_reset();
    end else if (m_booting) begin
      m_booting = 0;
      m_valid = 1;
    end else if (m_halted || bus.stall) begin
      // frozen
    end else begin
      case (bus.pc_sel)
        2'd0: t = nxt;
        2'd1: t = bus.br_taken ? nxt + bus.br_offset * 32'd4 : nxt;
        2'd2: t = (nxt & 32'hF000_0000) | ({6'd0, bus.jump_target} * 32'd4);
        default: t = bus.jr_addr;
      endcase
      if (t >= IB || (t % 4) != 0) begin
        m_fault = 1; m_fpc = t; m_halted = 1; m_valid = 0;
      end else begin
        m_pc = t;
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic st, input logic rs, input logic [1:0] sel,
                       input logic bt, input logic [31:0] off,
                       input logic [25:0] jt, input logic [31:0] jr);
    bus.stall = st; bus.restart = rs; bus.pc_sel = sel; bus.br_taken = bt;
    bus.br_offset = off; bus.jump_target = jt; bus.jr_addr = jr;
  endtask

  task automatic go_to(input logic [31:0] a);
    drive(0, 0, 2'd3, 0, 0, 0, a);
    cyc();
  endtask

  task automatic rand_drive();
    logic [31:0] off, jr;
    off = (($urandom_range(0, 7) == 0) ? $urandom : ($urandom_range(0, 63) - 32'd32));
    jr  = (($urandom_range(0, 5) == 0) ? $urandom : ($urandom_range(0, IB / 4 - 1) * 4));
    drive($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), off, 26'($urandom), jr);
  endtask

  initial begin
    drive(0, 0, 2'd0, 0, 0, 0, 0);
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1'b1;
    #1 check_all();

    // boot then sequential
    @(negedge clk);
    cyc();
    repeat (3) cyc();
    chk("seq_12", bus.pc, 32'h0000_000C);

    // branch taken backwards / not taken
    go_to(32'h40);
    drive(0, 0, 2'd1, 1, 32'hFFFF_FFFC, 0, 0); cyc();
    chk("br_taken", bus.pc, 32'h34);
    go_to(32'h40);
    drive(0, 0, 2'd1, 0, 32'hFFFF_FFFC, 0, 0); cyc();
    chk("br_not_taken", bus.pc, 32'h44);

    // jump and jump-register
    go_to(32'h100);
    drive(0, 0, 2'd2, 0, 0, 26'h0000200, 0); cyc();
    chk("jump", bus.pc, 32'h800);
    go_to(32'h1000);
    chk("jr", bus.pc, 32'h1000);

    // stall
    go_to(32'h20);
    drive(1, 0, 2'd2, 0, 0, 26'h0000200, 0);
    repeat (3) cyc();
    chk("stall_pc", bus.pc, 32'h20);
    chk("stall_fault", {31'd0, bus.fault}, 32'd0);

    // misaligned JR fault, then ignored stimulus
    drive(0, 0, 2'd3, 0, 0, 0, 32'h102); cyc();
    chk("jr_fault_pc", bus.fault_pc, 32'h102);
    chk("jr_fault_held", bus.pc, 32'h20);
    for (int i = 0; i < 6; i++) begin
      rand_drive(); bus.restart = 0; cyc();
    end

    // restart out of HALT
    drive(0, 1, 2'd0, 0, 0, 0, 0); cyc();
    chk("restart_fault", {31'd0, bus.fault}, 32'd0);
    drive(0, 0, 2'd0, 0, 0, 0, 0); cyc();
    chk("restart_run", {31'd0, bus.pc_valid}, 32'd1);

    // last legal word sequential
    go_to(32'h7FFC);
    drive(0, 0, 2'd0, 0, 0, 0, 0); cyc();
    chk("end_fault_pc", bus.fault_pc, 32'h8000);
    drive(0, 1, 2'd0, 0, 0, 0, 0); cyc();
    drive(0, 0, 2'd0, 0, 0, 0, 0);
    repeat (4) cyc();

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_pc", bus.pc, 32'h0);
    check_all();
    @(negedge clk) rst_n = 1'b1;
    #1 check_all();

    // randomized traffic with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      if ($urandom_range(0, 400) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
